// File: rtl/mc_phase_sequencer.sv
// Multi-cycle MIPS control sequencer: walks FETCH..WB per instruction class,
// stretching on memory wait-states and a multi-cycle execute, with run/step/halt control.
module mc_phase_sequencer #(
  parameter int EX_CYCLES = 1,
  parameter int CNTW      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            step_mode,
  input  logic            step,
  input  logic [5:0]      op,
  input  logic            mem_ready,
  output logic [4:0]      phase,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            ir_we,
  output logic            pc_inc,
  output logic            pc_jmp,
  output logic            br_en,
  output logic            ab_we,
  output logic            alu_we,
  output logic            gr_we,
  output logic            instr_done,
  output logic            illegal,
  output logic [CNTW-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] EX_LAST = 4'(EX_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      ex_cnt_q, ex_cnt_d;
  logic            illegal_q, illegal_d;
  logic [CNTW-1:0] retired_q, retired_d;

  logic op_j, op_r, op_lw, op_sw, op_beq, ex_last, free_run;
  state_t after_done;

  assign op_j     = (op == 6'b000010);
  assign op_r     = (op == 6'b000000);
  assign op_lw    = (op == 6'b100011);
  assign op_sw    = (op == 6'b101011);
  assign op_beq   = (op == 6'b000100);
  assign ex_last  = (ex_cnt_q == EX_LAST);
  assign free_run = run & ~step_mode;
  // Dropping run mid-instruction only takes effect here, at the boundary.
  assign after_done = free_run ? S_FETCH : S_IDLE;

  always_comb begin
    phase      = 5'b00000;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_we      = 1'b0;
    pc_inc     = 1'b0;
    pc_jmp     = 1'b0;
    br_en      = 1'b0;
    ab_we      = 1'b0;
    alu_we     = 1'b0;
    gr_we      = 1'b0;
    instr_done = 1'b0;
    state_d    = state_q;
    ex_cnt_d   = ex_cnt_q;
    illegal_d  = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (free_run || (step_mode && step)) state_d = S_FETCH;
      end
      S_FETCH: begin
        phase  = 5'b00001;
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        phase = 5'b00010;
        ab_we = 1'b1;
        if (op_j) begin
          pc_jmp     = 1'b1;
          instr_done = 1'b1;
          state_d    = after_done;
        end else if (op_r || op_lw || op_sw || op_beq) begin
          ex_cnt_d = 4'd0;
          state_d  = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC: begin
        phase = 5'b00100;
        if (ex_last) begin
          alu_we = 1'b1;
          if (op_beq) begin
            br_en      = 1'b1;
            instr_done = 1'b1;
            state_d    = after_done;
          end else if (op_lw || op_sw) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end else begin
          ex_cnt_d = ex_cnt_q + 4'd1;
        end
      end
      S_MEM: begin
        phase  = 5'b01000;
        mem_rd = op_lw;
        mem_wr = op_sw;
        if (mem_ready) begin
          if (op_lw) begin
            state_d = S_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = after_done;
          end
        end
      end
      S_WB: begin
        phase      = 5'b10000;
        gr_we      = 1'b1;
        instr_done = 1'b1;
        state_d    = after_done;
      end
      default: state_d = S_HALT;
    endcase
    retired_d = instr_done ? retired_q + CNTW'(1) : retired_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ex_cnt_q  <= 4'd0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ex_cnt_q  <= ex_cnt_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_phase_sequencer.sv
// Directed bench for mc_phase_sequencer: one instance with EX_CYCLES=1, one with
// EX_CYCLES=3 and a 2-bit retired counter to reach the wrap.
module tb_mc_phase_sequencer;

  localparam logic [9:0] RD  = 10'b10_0000_0000;
  localparam logic [9:0] WR  = 10'b01_0000_0000;
  localparam logic [9:0] IR  = 10'b00_1000_0000;
  localparam logic [9:0] PCI = 10'b00_0100_0000;
  localparam logic [9:0] JMP = 10'b00_0010_0000;
  localparam logic [9:0] BR  = 10'b00_0001_0000;
  localparam logic [9:0] AB  = 10'b00_0000_1000;
  localparam logic [9:0] ALU = 10'b00_0000_0100;
  localparam logic [9:0] GR  = 10'b00_0000_0010;
  localparam logic [9:0] DN  = 10'b00_0000_0001;

  localparam logic [4:0] P0 = 5'b00000, PF = 5'b00001, PD = 5'b00010,
                         PE = 5'b00100, PM = 5'b01000, PW = 5'b10000;

  // clock / reset / shared inputs
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0, step_mode = 1'b0, step = 1'b0, mem_ready = 1'b0;
  logic [5:0] op = 6'b000000;
  always #5 clk = ~clk;

  logic [4:0]  phase1, phase3;
  logic        rd1, wr1, ir1, pci1, jmp1, br1, ab1, alu1, gr1, dn1, ill1;
  logic        rd3, wr3, ir3, pci3, jmp3, br3, ab3, alu3, gr3, dn3, ill3;
  logic [31:0] ret1;
  logic [1:0]  ret3;

  mc_phase_sequencer #(.EX_CYCLES(1), .CNTW(32)) dut1 (
    .clk(clk), .reset(reset), .run(run), .step_mode(step_mode), .step(step),
    .op(op), .mem_ready(mem_ready), .phase(phase1), .mem_rd(rd1), .mem_wr(wr1),
    .ir_we(ir1), .pc_inc(pci1), .pc_jmp(jmp1), .br_en(br1), .ab_we(ab1),
    .alu_we(alu1), .gr_we(gr1), .instr_done(dn1), .illegal(ill1), .retired(ret1)
  );

  mc_phase_sequencer #(.EX_CYCLES(3), .CNTW(2)) dut3 (
    .clk(clk), .reset(reset), .run(run), .step_mode(step_mode), .step(step),
    .op(op), .mem_ready(mem_ready), .phase(phase3), .mem_rd(rd3), .mem_wr(wr3),
    .ir_we(ir3), .pc_inc(pci3), .pc_jmp(jmp3), .br_en(br3), .ab_we(ab3),
    .alu_we(alu3), .gr_we(gr3), .instr_done(dn3), .illegal(ill3), .retired(ret3)
  );

  logic        sel3 = 1'b0;
  logic [4:0]  obs_phase;
  logic [9:0]  obs_ctrl;
  logic [31:0] obs_ret;
  logic        obs_ill;
  assign obs_phase = sel3 ? phase3 : phase1;
  assign obs_ctrl  = sel3 ? {rd3, wr3, ir3, pci3, jmp3, br3, ab3, alu3, gr3, dn3}
                          : {rd1, wr1, ir1, pci1, jmp1, br1, ab1, alu1, gr1, dn1};
  assign obs_ret   = sel3 ? {30'd0, ret3} : ret1;
  assign obs_ill   = sel3 ? ill3 : ill1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply mem_ready, check phase and enables, then advance.
  task automatic cyc(input string tag, input logic mr, input logic [4:0] ep,
                     input logic [9:0] ec);
    mem_ready = mr;
    #1;
    chk({tag, ".phase"}, 32'(obs_phase), 32'(ep));
    chk({tag, ".ctrl"},  32'(obs_ctrl),  32'(ec));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0; step_mode = 1'b0; step = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.phase", 32'(obs_phase), 32'd0);
    chk("rst.ctrl", 32'(obs_ctrl), 32'd0);
    chk("rst.retired", obs_ret, 32'd0);
    chk("rst.illegal", 32'(obs_ill), 32'd0);
    reset = 1'b0;
  endtask

  logic [4:0] r_ph [4];
  logic [9:0] r_ct [4];
  logic [4:0] b_ph [5];
  logic [9:0] b_ct [5];

  initial begin
    r_ph = '{PF, PD, PE, PW};
    r_ct = '{RD | IR | PCI, AB, ALU, GR | DN};
    b_ph = '{PF, PD, PE, PE, PE};
    b_ct = '{RD | IR | PCI, AB, 10'd0, 10'd0, ALU | BR | DN};

    // Free-running R-type stream, EX_CYCLES=1
    do_reset();
    run = 1'b1; op = 6'b000000;
    cyc("r.idle", 1'b1, P0, 10'd0);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 4; k++)
        cyc($sformatf("r.i%0d.c%0d", i, k), 1'b1, r_ph[k], r_ct[k]);
    chk("r.retired", obs_ret, 32'd3);

    // lw with 2 fetch waits and 3 memory waits
    do_reset();
    run = 1'b1; op = 6'b100011;
    cyc("lw.idle", 1'b0, P0, 10'd0);
    cyc("lw.f0", 1'b0, PF, RD);
    cyc("lw.f1", 1'b0, PF, RD);
    cyc("lw.f2", 1'b1, PF, RD | IR | PCI);
    cyc("lw.d", 1'b0, PD, AB);
    cyc("lw.e", 1'b0, PE, ALU);
    cyc("lw.m0", 1'b0, PM, RD);
    cyc("lw.m1", 1'b0, PM, RD);
    cyc("lw.m2", 1'b0, PM, RD);
    cyc("lw.m3", 1'b1, PM, RD);
    cyc("lw.wb", 1'b0, PW, GR | DN);
    chk("lw.retired", obs_ret, 32'd1);
    chk("lw.next", 32'(obs_phase), 32'(PF));

    // sw with one memory wait, done in MEM
    do_reset();
    run = 1'b1; op = 6'b101011;
    cyc("sw.idle", 1'b1, P0, 10'd0);
    cyc("sw.f", 1'b1, PF, RD | IR | PCI);
    cyc("sw.d", 1'b1, PD, AB);
    cyc("sw.e", 1'b1, PE, ALU);
    cyc("sw.m0", 1'b0, PM, WR);
    cyc("sw.m1", 1'b1, PM, WR | DN);
    chk("sw.retired", obs_ret, 32'd1);
    chk("sw.next", 32'(obs_phase), 32'(PF));

    // beq on the EX_CYCLES=3 instance; 4 instructions wrap the 2-bit counter
    sel3 = 1'b1;
    do_reset();
    run = 1'b1; op = 6'b000100;
    cyc("beq.idle", 1'b1, P0, 10'd0);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 5; k++)
        cyc($sformatf("beq.i%0d.c%0d", i, k), 1'b1, b_ph[k], b_ct[k]);
    chk("beq.retired_wrap", obs_ret, 32'd0);
    chk("beq.next", 32'(obs_phase), 32'(PF));
    sel3 = 1'b0;

    // Single-step jumps
    do_reset();
    op = 6'b000010; step = 1'b1;
    cyc("st.nomode", 1'b1, P0, 10'd0);
    step_mode = 1'b1; step = 1'b0;
    cyc("st.wait", 1'b1, P0, 10'd0);
    step = 1'b1;
    cyc("st.pulse", 1'b1, P0, 10'd0);
    step = 1'b0;
    cyc("st.f", 1'b1, PF, RD | IR | PCI);
    cyc("st.d", 1'b1, PD, AB | JMP | DN);
    cyc("st.idle0", 1'b1, P0, 10'd0);
    cyc("st.idle1", 1'b1, P0, 10'd0);
    chk("st.retired", obs_ret, 32'd1);
    step = 1'b1;
    cyc("st.held.idle", 1'b1, P0, 10'd0);
    cyc("st.held.f", 1'b1, PF, RD | IR | PCI);
    cyc("st.held.d", 1'b1, PD, AB | JMP | DN);
    cyc("st.held.idle2", 1'b1, P0, 10'd0);
    cyc("st.held.f2", 1'b1, PF, RD | IR | PCI);
    step = 1'b0;
    cyc("st.held.d2", 1'b1, PD, AB | JMP | DN);
    cyc("st.end", 1'b1, P0, 10'd0);
    chk("st.retired3", obs_ret, 32'd3);

    // Illegal opcode halts until reset
    do_reset();
    run = 1'b1; op = 6'b111111;
    cyc("ill.idle", 1'b1, P0, 10'd0);
    cyc("ill.f", 1'b1, PF, RD | IR | PCI);
    chk("ill.pre", 32'(obs_ill), 32'd0);
    cyc("ill.d", 1'b1, PD, AB);
    op = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("ill.halt%0d", i), 1'b1, P0, 10'd0);
      chk("ill.flag", 32'(obs_ill), 32'd1);
    end
    chk("ill.retired", obs_ret, 32'd0);
    do_reset();
    chk("ill.cleared", 32'(obs_ill), 32'd0);

    // Reset asserted during sw memory wait drops mem_wr at once
    run = 1'b1; op = 6'b101011;
    cyc("ab.idle", 1'b1, P0, 10'd0);
    cyc("ab.f", 1'b1, PF, RD | IR | PCI);
    cyc("ab.d", 1'b1, PD, AB);
    cyc("ab.e", 1'b1, PE, ALU);
    mem_ready = 1'b0;
    #1;
    chk("ab.mem_wr", 32'(obs_ctrl), 32'(WR));
    reset = 1'b1;
    #1;
    chk("ab.async_ctrl", 32'(obs_ctrl), 32'd0);
    chk("ab.async_phase", 32'(obs_phase), 32'd0);
    @(posedge clk);
    #1;
    chk("ab.held_ctrl", 32'(obs_ctrl), 32'd0);
    do_reset();

    // Dropping run mid R-type finishes the instruction then idles
    run = 1'b1; op = 6'b000000;
    cyc("rr.idle", 1'b1, P0, 10'd0);
    cyc("rr.f", 1'b1, PF, RD | IR | PCI);
    run = 1'b0;
    cyc("rr.d", 1'b1, PD, AB);
    cyc("rr.e", 1'b1, PE, ALU);
    cyc("rr.wb", 1'b1, PW, GR | DN);
    cyc("rr.idle1", 1'b1, P0, 10'd0);
    cyc("rr.idle2", 1'b1, P0, 10'd0);
    chk("rr.retired", obs_ret, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_phase_sequencer.md
Name: mc_phase_sequencer

Overview:
- Clocked control sequencer for the multi-cycle MIPS datapath.
- Generates the one-hot phase vector (bit 0 fetch, 1 decode, 2 execute, 3 memory, 4 writeback) and the per-register write enables.
- Previously the phase vector was driven from outside the CPU. This block replaces that, and adds:
  - a variable phase count per instruction class,
  - memory wait-states,
  - a multi-cycle execute stage,
  - single-step and halt.

Parameters:
- EX_CYCLES, 1, cycles spent in execute phase (1..15).
- CNTW, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock (all state on rising edge)
- reset  in  1  asynchronous, active-high reset
- run  in  1  enable free-running execution
- step_mode  in  1  1 = execute one instruction per step pulse
- step  in  1  start one instruction (sampled only in IDLE with step_mode=1)
- op  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory access completes this cycle
- phase  out  5  one-hot current phase; 0 in IDLE/HALT
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- ir_we  out  1  IR load
- pc_inc  out  1  PC increment
- pc_jmp  out  1  PC load jump target
- br_en  out  1  PC load branch target if ALU zero
- ab_we  out  1  A/B register load
- alu_we  out  1  ALUOut load
- gr_we  out  1  register-file write
- instr_done  out  1  one-cycle pulse on last cycle of an instruction
- illegal  out  1  sticky: unsupported opcode decoded
- retired  out  CNTW  count of completed instructions

Behaviour:
- **States:** IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. phase = one-hot of FETCH..WB, otherwise 0.
- **Reset:** async to IDLE. All outputs 0, retired=0, illegal=0, EX counter=0. Reset mid-instruction aborts it with no further enables.
- **Outputs:** combinational from state, EX counter, op and mem_ready. No output depends on run or step.
- **IDLE:** go to FETCH next cycle when (run & !step_mode) or (step_mode & step). Otherwise stay.
- **FETCH:** mem_rd=1 every cycle. When mem_ready=1: ir_we=1 and pc_inc=1 for that cycle only, then go to DECODE. Wait indefinitely otherwise.
- **DECODE** (1 cycle): ab_we=1.
  - op=000010 (j): pc_jmp=1, instruction done.
  - op in {000000, 100011, 101011, 000100}: go to EXEC.
  - Any other op: illegal←1, go to HALT; instr_done stays 0.
- **EXEC:** counter counts 0..EX_CYCLES-1. alu_we=1 only on the last count.
  - beq (000100): br_en=1 on the last count, done.
  - lw/sw: go to MEM.
  - R-type: go to WB.
- **MEM:** mem_rd=1 for lw, mem_wr=1 for sw, every cycle until mem_ready.
  - On the mem_ready cycle: lw goes to WB; sw is done.
- **WB** (1 cycle): gr_we=1, done.
- **Phase counts:** j 2, beq 2+EX_CYCLES, R 3+EX_CYCLES, sw 3+EX_CYCLES+waits, lw 4+EX_CYCLES+waits.
- **Done cycle:**
  - instr_done=1 in the same cycle as the final enable.
  - retired increments, wrapping modulo 2^CNTW.
  - Next state is FETCH if run & !step_mode, else IDLE.
- **Run/step changes:**
  - Deasserting run mid-instruction does not abort; the instruction finishes, then the block goes to IDLE.
  - step is ignored outside IDLE and when step_mode=0.
  - step held high re-triggers in each IDLE visit, so exactly 1 instruction runs per IDLE→FETCH entry.
- **HALT:** all enables 0, phase 0. Exit only by reset.
- **Exclusivity:** at most one of mem_rd/mem_wr is high. Enables are never high outside their listed state.

Test Plan:
- Reset then run=1, mem_ready=1 always, op=000000, EX_CYCLES=1 → phase 00001,00010,00100,10000 repeating. gr_we high on the 4th cycle together with instr_done; retired=3 after 12 cycles.
- lw (100011) with mem_ready low 2 cycles in FETCH and 3 cycles in MEM → mem_rd high 3 cycles in FETCH, ir_we once, mem_rd high 4 cycles in MEM, gr_we in WB. Total 10 cycles, retired+1.
- EX_CYCLES=3, beq → EXEC phase lasts 3 cycles; alu_we and br_en only on the 3rd; no WB; next phase 00001.
- step_mode=1, one-cycle step pulse, op=000010 → FETCH, DECODE with pc_jmp=1 and instr_done=1, then IDLE with phase=0 until the next step.
- op=111111 in DECODE → illegal=1, phase=0 thereafter, retired unchanged; assert reset → illegal=0, IDLE.
- Assert reset during MEM of sw → mem_wr drops asynchronously, all outputs 0; run=0 mid R-type → WB completes, then IDLE.
